// File: rtl/dm_lane_bridge_pkg.sv
// Shared definitions for the MEM-stage data-memory bridge: access sizes,
// address-exception codes (shared with CP0), FSM encoding and lane helpers.
package dm_lane_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic [4:0] EXC_CODE_ADEL = 5'd4;
  localparam logic [4:0] EXC_CODE_ADES = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores are replicated across lanes so the byte enables alone pick the target.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_bridge_load_lane_ext.sv
// Combinational load-lane extractor: picks the addressed byte/half out of a
// bus word and zero- or sign-extends it to 32 bits; words pass through.
module load_lane_ext
  import dm_lane_bridge_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    shifted   = word >> {offset, 3'b000};
    byte_lane = shifted[7:0];
    half_lane = shifted[15:0];
    case (size)
      SZ_BYTE: result = {{24{sign & byte_lane[7]}}, byte_lane};
      SZ_HALF: result = {{16{sign & half_lane[15]}}, half_lane};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dm_lane_bridge.sv
// MEM-stage data-memory bridge: lane steering for stores, lane extraction for
// loads, req/ack bus handshake with pipeline stall, and AdEL/AdES detection.
module dm_lane_bridge
  import dm_lane_bridge_pkg::*;
#(
  parameter logic [4:0] EXC_ADEL = EXC_CODE_ADEL,
  parameter logic [4:0] EXC_ADES = EXC_CODE_ADES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;

  logic        misaligned;
  logic        accept;
  logic [31:0] ext_rdata;

  load_lane_ext u_ext (
    .word   (bus_rdata),
    .offset (off_q),
    .size   (size_q),
    .sign   (sign_q),
    .result (ext_rdata)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    sign_d     = sign_q;
    off_d      = off_q;
    rdata_d    = rdata_q;

    misaligned = is_misaligned(req_size, req_addr[1:0]);
    accept     = (state_q == ST_IDLE) && req_valid && !misaligned;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          we_d    = req_we;
          addr_d  = {req_addr[31:2], 2'b00};
          be_d    = lane_be(req_size, req_addr[1:0]);
          wdata_d = lane_wdata(req_size, req_wdata);
          size_d  = req_size;
          sign_d  = req_sign;
          off_d   = req_addr[1:0];
        end
      end
      ST_BUSY: begin
        if (bus_ack) begin
          state_d = ST_DONE;
          if (!we_q) rdata_d = ext_rdata;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_stall  = accept || (state_q == ST_BUSY);
    exc_valid  = (state_q == ST_IDLE) && req_valid && misaligned;
    exc_code   = exc_valid ? (req_we ? EXC_ADES : EXC_ADEL) : 5'd0;
    bus_req    = (state_q == ST_BUSY);
    resp_valid = (state_q == ST_DONE) && !we_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      size_q  <= SZ_BYTE;
      sign_q  <= 1'b0;
      off_q   <= 2'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dm_lane_bridge.sv
// Randomized self-checking bench for dm_lane_bridge against an arithmetic
// reference model of lane mapping, extension, exceptions and handshake timing.
module tb_dm_lane_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_sign;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_stall, resp_valid, exc_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  exc_code;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks   = 0;
  int failures = 0;
  logic [31:0] model_rdata;

  dm_lane_bridge dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_stall(req_stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return addr[0];
    if (size == 2'd2) return addr[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr[1:0]);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return 4'(3 << (2 * (off / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sign,
                                             input logic [31:0] addr, input logic [31:0] rd);
    int off = int'(addr[1:0]);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // One full transaction from request cycle T through the cycle after DONE.
  task automatic run_txn(input int id, input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int k);
    logic mis;
    mis = model_mis(size, addr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
    req_addr = addr; req_wdata = wdata; bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    check_eq("exc_valid_T", 32'(exc_valid), 32'(mis));
    check_eq("exc_code_T", 32'(exc_code), mis ? (we ? 32'd5 : 32'd4) : 32'd0);
    check_eq("stall_T", 32'(req_stall), 32'(!mis));
    check_eq("bus_req_T", 32'(bus_req), 32'd0);
    if (mis) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check_eq("bus_req_after_exc", 32'(bus_req), 32'd0);
      check_eq("resp_rdata_after_exc", resp_rdata, model_rdata);
      $display("txn %0d exc we=%0b size=%0d addr=0x%08h code=%0d", id, we, size, addr, exc_code);
      return;
    end
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      bus_ack = (i == k);
      bus_rdata = (i == k) ? rdata : $urandom;
      #1;
      check_eq("bus_req_busy", 32'(bus_req), 32'd1);
      check_eq("stall_busy", 32'(req_stall), 32'd1);
      check_eq("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
      check_eq("bus_be", 32'(bus_be), 32'(model_be(size, addr)));
      check_eq("bus_we", 32'(bus_we), 32'(we));
      check_eq("bus_wdata", bus_wdata, model_wdata(size, wdata));
      check_eq("resp_valid_busy", 32'(resp_valid), 32'd0);
    end
    if (!we) model_rdata = model_load(size, sign, addr, rdata);
    @(negedge clk);
    bus_ack = $urandom_range(0, 1); bus_rdata = $urandom;
    #1;
    check_eq("resp_valid_done", 32'(resp_valid), 32'(!we));
    check_eq("resp_rdata_done", resp_rdata, model_rdata);
    check_eq("stall_done", 32'(req_stall), 32'd0);
    check_eq("bus_req_done", 32'(bus_req), 32'd0);
    @(negedge clk);
    req_valid = 1'b0; bus_ack = 1'b1; bus_rdata = $urandom;
    #1;
    check_eq("resp_valid_idle", 32'(resp_valid), 32'd0);
    check_eq("bus_req_idle", 32'(bus_req), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check_eq("spurious_ack_bus_req", 32'(bus_req), 32'd0);
    check_eq("spurious_ack_rdata", resp_rdata, model_rdata);
    $display("txn %0d we=%0b size=%0d sign=%0b addr=0x%08h k=%0d rdata=0x%08h", id, we, size,
             sign, addr, k, resp_rdata);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_sign = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    model_rdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_bus_req", 32'(bus_req), 32'd0);
    check_eq("rst_bus_we", 32'(bus_we), 32'd0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_bus_be", 32'(bus_be), 32'd0);
    check_eq("rst_bus_wdata", bus_wdata, 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);

    // Directed cases from the intended usage, then random traffic.
    run_txn(0, 1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_1234, 1);
    check_eq("lb_value", resp_rdata, 32'hFFFF_FF80);
    run_txn(1, 1'b0, 2'd1, 1'b0, 32'h0000_0022, 32'h0, 32'h8001_0000, 2);
    check_eq("lhu_value", resp_rdata, 32'h0000_8001);
    run_txn(2, 1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1);
    run_txn(3, 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1);
    run_txn(4, 1'b1, 2'd2, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 1);
    run_txn(5, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 4);

    for (int n = 6; n < 206; n++) begin
      run_txn(n, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
              int'($urandom_range(1, 5)));
    end

    // Reset while BUSY; the ack that arrives afterwards must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0000_0200;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check_eq("midrst_busy", 32'(bus_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    #1;
    check_eq("midrst_bus_req", 32'(bus_req), 32'd0);
    check_eq("midrst_stall", 32'(req_stall), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check_eq("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("midrst_resp_rdata", resp_rdata, 32'd0);
    check_eq("midrst_bus_req2", 32'(bus_req), 32'd0);
    $display("txn reset-while-busy bus_req=%0b resp_rdata=0x%08h", bus_req, resp_rdata);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
